// File: rtl/core_pkg.sv
// core_pkg: shared decode enums and execution sequencer state type.
package core_pkg;
  typedef enum logic [1:0] {CTRL_EXEC, CTRL_MEM, CTRL_AMO} ctrl_path_e;
  typedef enum logic [2:0] {ENG_ALU, ENG_MUL, ENG_DIV, ENG_RSV, ENG_CSR} exec_engine_e;
  typedef enum logic [2:0] {S_IDLE, S_ENGINE, S_MEM, S_AMO_RD, S_AMO_WR} exec_seq_state_e;
  function automatic logic is_muldiv(exec_engine_e e);
    return e == ENG_MUL || e == ENG_DIV;
  endfunction
endpackage

// File: rtl/core_exec_watchdog.sv
// core_exec_watchdog: wait-state cycle counter that flags expiry at TIMEOUT_CYCLES-1.
module core_exec_watchdog #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [W-1:0] count;
  always_ff @(posedge clk)
    if (rst || clear) count <= '0;
    else if (enable) count <= count + 1'b1;
  assign expired = enable && count == W'(TIMEOUT_CYCLES - 1);
endmodule

// File: rtl/core_exec_seq.sv
// core_exec_seq: sequences EXEC/MEM/AMO operations; CORE_EXEC_TIMEOUT_EN adds a wait-state watchdog.
module core_exec_seq import core_pkg::*; #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  ctrl_path_e   ctrl_path,
  input  exec_engine_e exec_engine,
  input  logic         illegal_instr,
  input  logic         kill,
  output logic         eng_start,
  input  logic         eng_done,
  output logic         mem_req,
  input  logic         mem_ready,
  input  logic         mem_err,
  output logic         exec_phase,
  output logic         busy,
  output logic         done,
  output logic         trap,
  output logic         timeout
);
  exec_seq_state_e st, nx;
  logic d_n, t_n, to_n, es_n, expired;
`ifdef CORE_EXEC_TIMEOUT_EN
  core_exec_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wd (
    .clk(clk), .rst(rst), .clear(st != nx), .enable(busy), .expired(expired)
  );
`else
  logic unused_cfg;
  assign unused_cfg = ^TIMEOUT_CYCLES;
  assign expired = 1'b0;
`endif
  always_comb begin
    nx = st;
    d_n = 1'b0;
    t_n = 1'b0;
    to_n = 1'b0;
    es_n = 1'b0;
    case (st)
      S_IDLE: if (start) begin
        d_n = illegal_instr || (ctrl_path == CTRL_EXEC && !is_muldiv(exec_engine));
        t_n = illegal_instr;
        es_n = !illegal_instr && ctrl_path == CTRL_EXEC && is_muldiv(exec_engine);
        nx = illegal_instr ? S_IDLE : es_n ? S_ENGINE : ctrl_path == CTRL_MEM ? S_MEM :
             ctrl_path == CTRL_AMO ? S_AMO_RD : S_IDLE;
      end
      S_ENGINE: if (eng_done) begin
        nx = S_IDLE;
        d_n = 1'b1;
      end
      S_AMO_RD: if (mem_ready) begin
        nx = mem_err ? S_IDLE : S_AMO_WR;
        d_n = mem_err;
        t_n = mem_err;
      end
      S_MEM, S_AMO_WR: if (mem_ready) begin
        nx = S_IDLE;
        d_n = 1'b1;
        t_n = mem_err;
      end
      default: nx = S_IDLE;
    endcase
    // a completion in the expiry cycle moves nx, so it wins over the watchdog
    if (expired && nx == st) begin
      nx = S_IDLE;
      d_n = 1'b1;
      t_n = 1'b1;
      to_n = 1'b1;
    end
    if (kill) begin
      nx = S_IDLE;
      d_n = 1'b0;
      t_n = 1'b0;
      to_n = 1'b0;
      es_n = 1'b0;
    end
  end
  always_ff @(posedge clk)
    if (rst) begin
      st <= S_IDLE;
      done <= 1'b0;
      trap <= 1'b0;
      timeout <= 1'b0;
      eng_start <= 1'b0;
    end else begin
      st <= nx;
      done <= d_n;
      trap <= t_n;
      timeout <= to_n;
      eng_start <= es_n;
    end
  assign busy = st != S_IDLE;
  assign mem_req = st == S_MEM || st == S_AMO_RD || st == S_AMO_WR;
  assign exec_phase = st == S_AMO_WR;
endmodule
